// File: rtl/l1_cache_pkg.sv
// Shared types, field widths and address-slice helpers for the L1 data cache.
package l1_cache_pkg;

    localparam int LINES    = 32;
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = 4;
    localparam int BADDR_W  = 16;
    localparam int ADDR_W   = BADDR_W + OFFSET_W;
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int BLOCK_W  = 128;
    localparam int WORD_W   = 32;
    localparam int WSEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        GAP    = 2'd2,
        REFILL = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WSEL_W];
    endfunction

    function automatic logic [BADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: BADDR_W];
    endfunction

    // Byte-masked write of one word into a line.
    function automatic logic [BLOCK_W-1:0] merge_word(input logic [BLOCK_W-1:0] line,
                                                      input logic [WSEL_W-1:0]  sel,
                                                      input logic [WORD_W-1:0]  data,
                                                      input logic [3:0]         be);
        logic [BLOCK_W-1:0] r;
        r = line;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[{sel, 2'(b), 3'd0} +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/l1_dcache_array.sv
// Tag/valid/dirty/data storage: asynchronous read at one index, single write
// port that either fills a whole line (valid=1, dirty=0) or merges one word (dirty=1).
module l1_dcache_array
    import l1_cache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [INDEX_W-1:0]  index,
    output logic [TAG_W-1:0]    rd_tag,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [BLOCK_W-1:0]  rd_line,
    input  logic                wr_fill,
    input  logic [TAG_W-1:0]    wr_tag,
    input  logic [BLOCK_W-1:0]  wr_line,
    input  logic                wr_word,
    input  logic [WSEL_W-1:0]   wr_sel,
    input  logic [WORD_W-1:0]   wr_data,
    input  logic [3:0]          wr_be
);

    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [BLOCK_W-1:0] data_q [LINES];
    logic [BLOCK_W-1:0] data_d [LINES];
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;

    assign rd_tag   = tag_q[index];
    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_line  = data_q[index];

    // Apply the single write port; a fill takes precedence over a word merge
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_fill) begin
            tag_d[index]   = wr_tag;
            data_d[index]  = wr_line;
            valid_d[index] = 1'b1;
            dirty_d[index] = 1'b0;
        end else if (wr_word) begin
            data_d[index]  = merge_word(data_q[index], wr_sel, wr_data, wr_be);
            dirty_d[index] = 1'b1;
        end
    end

    // Storage registers; reset invalidates every line
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINES; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            tag_q   <= tag_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

endmodule

// File: rtl/l1_dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined;
// otherwise stat_hits/stat_misses are tied to 0.
module l1_dcache
    import l1_cache_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                cpu_ren,
    input  logic                cpu_wen,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [WORD_W-1:0]   cpu_wdata,
    input  logic [3:0]          cpu_be,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic                cpu_stall,
    output logic                mem_ren,
    output logic                mem_wen,
    output logic [BADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0]  mem_wdata,
    input  logic [BLOCK_W-1:0]  mem_rdata,
    input  logic                mem_ready,
    input  logic                mem_done,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses
);

    state_t               state_q, state_d;
    logic                 mem_ren_q, mem_ren_d;
    logic                 mem_wen_q, mem_wen_d;
    logic [BADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [WORD_W-1:0]    rdata_q, rdata_d;

    logic [INDEX_W-1:0]   idx;
    logic [TAG_W-1:0]     tag;
    logic [WSEL_W-1:0]    wsel;
    logic [TAG_W-1:0]     rd_tag;
    logic                 rd_valid, rd_dirty;
    logic [BLOCK_W-1:0]   rd_line;
    logic [WORD_W-1:0]    rd_word;
    logic                 req, hit, idle_hit, miss_start, wb_done, refill_done;
    logic                 arr_fill, arr_word;

    assign idx         = addr_index(cpu_addr);
    assign tag         = addr_tag(cpu_addr);
    assign wsel        = addr_word(cpu_addr);
    assign rd_word     = rd_line[{wsel, 5'd0} +: WORD_W];
    assign req         = cpu_ren | cpu_wen;
    assign hit         = rd_valid && (rd_tag == tag);
    assign idle_hit    = (state_q == IDLE) && req && hit;
    assign miss_start  = (state_q == IDLE) && req && !hit;
    assign wb_done     = (state_q == WB) && mem_wen_q && mem_done;
    assign refill_done = (state_q == REFILL) && mem_ren_q && mem_done;

    l1_dcache_array u_array (
        .clock    (clock),
        .reset    (reset),
        .index    (idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_line  (rd_line),
        .wr_fill  (arr_fill),
        .wr_tag   (tag),
        .wr_line  (mem_rdata),
        .wr_word  (arr_word),
        .wr_sel   (wsel),
        .wr_data  (cpu_wdata),
        .wr_be    (cpu_be)
    );

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: a miss evicts a dirty victim first, otherwise refills directly
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_start) state_d = (rd_valid && rd_dirty) ? WB : REFILL;
            WB:      if (wb_done) state_d = GAP;
            GAP:     state_d = REFILL;
            REFILL:  if (refill_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: Dmem request launch/drop, array writes and load-data capture
    always_comb begin
        mem_ren_d   = mem_ren_q;
        mem_wen_d   = mem_wen_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        arr_fill    = 1'b0;
        arr_word    = 1'b0;
        case (state_q)
            IDLE: begin
                if (idle_hit) begin
                    if (cpu_wen) arr_word = 1'b1;
                    else         rdata_d  = rd_word;
                end
            end
            WB: begin
                if (!mem_wen_q && mem_ready) begin
                    mem_wen_d   = 1'b1;
                    mem_addr_d  = {rd_tag, idx};
                    mem_wdata_d = rd_line;
                end else if (wb_done) begin
                    mem_wen_d   = 1'b0;
                end
            end
            REFILL: begin
                if (!mem_ren_q && mem_ready) begin
                    mem_ren_d  = 1'b1;
                    mem_addr_d = addr_block(cpu_addr);
                end else if (refill_done) begin
                    mem_ren_d  = 1'b0;
                    arr_fill   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered Dmem interface and held load data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_ren_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            mem_ren_q   <= mem_ren_d;
            mem_wen_q   <= mem_wen_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign mem_ren   = mem_ren_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rdata = (idle_hit && !cpu_wen) ? rd_word : rdata_q;
    assign cpu_stall = reset && req && !idle_hit;

`ifdef DCACHE_STATS_EN
    logic [31:0] hits_q, hits_d;
    logic [31:0] misses_q, misses_d;
    logic        relookup_q, relookup_d;

    // Count first-lookup hits and miss entries; the hit right after a refill is excluded
    always_comb begin
        hits_d     = hits_q;
        misses_d   = misses_q;
        relookup_d = relookup_q;
        if (state_q == IDLE) relookup_d = 1'b0;
        if (refill_done)     relookup_d = 1'b1;
        if (idle_hit && !relookup_q) hits_d = hits_q + 32'd1;
        if (miss_start)              misses_d = misses_q + 32'd1;
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hits_q     <= '0;
            misses_q   <= '0;
            relookup_q <= 1'b0;
        end else begin
            hits_q     <= hits_d;
            misses_q   <= misses_d;
            relookup_q <= relookup_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_l1_dcache.sv
// Randomized scoreboard bench for l1_dcache with a behavioural Dmem.
module tb_l1_dcache;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         cpu_ren = 1'b0, cpu_wen = 1'b0;
    logic [19:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [3:0]   cpu_be = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_ren, mem_wen;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata = '0;
    logic         mem_ready = 1'b1;
    logic         mem_done = 1'b0;
    logic [31:0]  stat_hits, stat_misses;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    l1_dcache dut (
        .clock(clock), .reset(reset),
        .cpu_ren(cpu_ren), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_done(mem_done),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Dmem storage and reference memory ----------------
    logic [127:0] dmem [int];
    logic [31:0]  ref_w [int];

    function automatic logic [31:0] init_word(input int blk, input int w);
        return (32'(blk) * 32'h0001_0003) ^ (32'(w) << 28) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [127:0] dmem_rd(input int blk);
        logic [127:0] b;
        if (dmem.exists(blk)) return dmem[blk];
        for (int w = 0; w < 4; w++) b[w*32 +: 32] = init_word(blk, w);
        return b;
    endfunction

    function automatic logic [31:0] ref_rd(input int wa);
        logic [127:0] b;
        if (ref_w.exists(wa)) return ref_w[wa];
        b = dmem_rd(wa >> 2);
        return b[(wa & 3)*32 +: 32];
    endfunction

    function automatic logic [127:0] ref_line(input int blk);
        logic [127:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = ref_rd(blk*4 + w);
        return l;
    endfunction

    // ---------------- scoreboard queues and cache-content model ----------------
    typedef struct { bit is_load; logic [31:0] rdata; bit hit; } resp_t;
    typedef struct { bit wr; logic [15:0] addr; logic [127:0] data; } memtx_t;
    resp_t  exp_q [$];
    memtx_t exp_mem [$];

    int mtag [32];
    bit mval [32];
    bit mdirty [32];
    int m_hits = 0, m_misses = 0;

    // ---------------- Dmem behavioural model ----------------
    int d_busy = 0, d_cnt = 0, d_wr = 0, d_addr = 0, min_lat = 0;
    int done_cyc_ren = -10;
    logic [127:0] d_data;
    memtx_t got_tx;

    always @(negedge clock) begin
        if (!reset) begin
            mem_ready = 1'b1;
            mem_done  = 1'b0;
            d_busy    = 0;
        end else if (mem_done) begin
            mem_done = 1'b0;
            d_busy   = 0;
            mem_ready = 1'b1;
            check("req_dropped_after_done", {mem_ren, mem_wen}, 2'b00);
        end else if (d_busy == 0) begin
            if (mem_ren || mem_wen) begin
                check("ren_wen_exclusive", mem_ren && mem_wen, 1'b0);
                check("req_only_when_ready", mem_ready, 1'b1);
                if (exp_mem.size() == 0) begin
                    check("unexpected_mem_txn", {mem_wen, mem_addr}, 17'h0);
                end else begin
                    got_tx = exp_mem.pop_front();
                    check("mem_txn_is_write", mem_wen, got_tx.wr);
                    check("mem_txn_addr", mem_addr, got_tx.addr);
                    if (got_tx.wr) check("mem_wb_data", mem_wdata, got_tx.data);
                end
                d_busy = 1;
                mem_ready = 1'b0;
                d_cnt  = min_lat + int'($urandom_range(0, 3));
                d_wr   = int'(mem_wen);
                d_addr = int'(mem_addr);
                d_data = mem_wdata;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
        end else if (d_cnt == 0) begin
            if (d_wr != 0) dmem[d_addr] = d_data;
            else begin
                mem_rdata    = dmem_rd(d_addr);
                done_cyc_ren = cyc;
            end
            mem_done = 1'b1;
        end else begin
            d_cnt--;
        end
    end

    // ---------------- response monitor ----------------
    bit    stalled_seen = 0;
    resp_t got_r;

    always @(negedge clock) begin
        if (!reset) stalled_seen = 0;
        else if (cpu_ren || cpu_wen) begin
            if (cpu_stall) stalled_seen = 1;
            else begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 1'b1, 1'b0);
                end else begin
                    got_r = exp_q.pop_front();
                    check("zero_wait_iff_hit", !stalled_seen, got_r.hit);
                    if (got_r.is_load) check("load_rdata", cpu_rdata, got_r.rdata);
                    if (!got_r.hit) check("stall_drop_after_done", cyc, done_cyc_ren + 1);
                end
                stalled_seen = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic predict(input bit st, input logic [19:0] a, input logic [31:0] wd, input logic [3:0] be);
        int idx, tg, wa;
        bit hit;
        resp_t r;
        memtx_t t;
        logic [31:0] w;
        idx = int'(a[8:4]);
        tg  = int'(a[19:9]);
        wa  = int'(a[19:2]);
        hit = mval[idx] && (mtag[idx] == tg);
        if (!hit) begin
            if (mval[idx] && mdirty[idx]) begin
                t.wr = 1;
                t.addr = 16'((mtag[idx] << 5) | idx);
                t.data = ref_line((mtag[idx] << 5) | idx);
                exp_mem.push_back(t);
            end
            t.wr = 0;
            t.addr = a[19:4];
            t.data = '0;
            exp_mem.push_back(t);
            mtag[idx] = tg;
            mval[idx] = 1;
            mdirty[idx] = 0;
            m_misses++;
        end else begin
            m_hits++;
        end
        if (st) begin
            w = ref_rd(wa);
            for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            ref_w[wa] = w;
            mdirty[idx] = 1;
        end
        r.is_load = !st;
        r.rdata   = ref_rd(wa);
        r.hit     = hit;
        exp_q.push_back(r);
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that completes the access
    task automatic do_access(input bit st, input logic [19:0] a, input logic [31:0] wd, input logic [3:0] be);
        int n;
        predict(st, a, wd, be);
        cpu_ren = !st;
        cpu_wen = st;
        cpu_addr = a;
        cpu_wdata = wd;
        cpu_be = be;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (cpu_stall && n < 300);
        if (cpu_stall) begin
            check("access_timeout", 1'b1, 1'b0);
            exp_q.delete();
            exp_mem.delete();
        end
        @(posedge clock);
        #1;
        cpu_ren = 1'b0;
        cpu_wen = 1'b0;
        check("mem_txns_all_seen", exp_mem.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    logic [127:0] blk;
    logic [31:0]  iw;
    int           n5;

    initial begin
        for (int i = 0; i < 32; i++) begin
            mval[i] = 0;
            mdirty[i] = 0;
            mtag[i] = 0;
        end
        repeat (3) @(posedge clock);
        #1;
        check("rst_mem_ren", mem_ren, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_mem_wdata", mem_wdata, 128'h0);
        check("rst_cpu_rdata", cpu_rdata, 32'h0);
        check("rst_cpu_stall", cpu_stall, 1'b0);
        check("rst_stat_hits", stat_hits, 32'h0);
        check("rst_stat_misses", stat_misses, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // cold read, store/load hit, dirty conflict, partial store miss
        do_access(0, 20'h00010, 32'h0, 4'h0);
        do_access(1, 20'h00010, 32'hDEADBEEF, 4'hF);
        do_access(0, 20'h00010, 32'h0, 4'h0);
        do_access(0, 20'h00210, 32'h0, 4'h0);
        blk = dmem_rd(1);
        check("wb_block1_word0", blk[31:0], 32'hDEADBEEF);
        do_access(1, 20'h00404, 32'h0000AAAA, 4'b0011);
`ifdef DCACHE_STATS_EN
        check("stat_hits_after_1to4", stat_hits, 32'd2);
        check("stat_misses_after_1to4", stat_misses, 32'd3);
`else
        check("stat_hits_disabled", stat_hits, 32'd0);
        check("stat_misses_disabled", stat_misses, 32'd0);
`endif
        do_access(0, 20'h00404, 32'h0, 4'h0);
        do_access(0, 20'h00004, 32'h0, 4'h0);
        blk = dmem_rd(16'h40);
        iw  = init_word(16'h40, 1);
        check("store_miss_low_half", blk[47:32], 16'hAAAA);
        check("store_miss_high_half", blk[63:48], iw[31:16]);

        // random traffic over a few indices and tags to force conflicts
        for (int k = 0; k < 250; k++) begin
            logic [19:0] ra;
            ra = {11'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
            do_access(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end
`ifdef DCACHE_STATS_EN
        check("stat_hits_random", stat_hits, 32'(m_hits));
        check("stat_misses_random", stat_misses, 32'(m_misses));
`else
        check("stat_hits_random_off", stat_hits, 32'd0);
        check("stat_misses_random_off", stat_misses, 32'd0);
`endif

        // reset while the refill is waiting for completion
        min_lat = 8;
        predict(0, 20'h00820, 32'h0, 4'h0);
        cpu_ren = 1'b1;
        cpu_addr = 20'h00820;
        n5 = 0;
        while (!mem_ren && n5 < 300) begin
            @(negedge clock);
            n5++;
        end
        check("refill_started", mem_ren, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("abort_mem_ren", mem_ren, 1'b0);
        check("abort_mem_wen", mem_wen, 1'b0);
        check("abort_cpu_stall", cpu_stall, 1'b0);
        cpu_ren = 1'b0;
        exp_q.delete();
        exp_mem.delete();
        ref_w.delete();
        for (int i = 0; i < 32; i++) begin
            mval[i] = 0;
            mdirty[i] = 0;
        end
        m_hits = 0;
        m_misses = 0;
        min_lat = 0;
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_access(0, 20'h00820, 32'h0, 4'h0);
`ifdef DCACHE_STATS_EN
        check("stat_hits_after_reset", stat_hits, 32'd0);
        check("stat_misses_after_reset", stat_misses, 32'd1);
`else
        check("stat_misses_after_reset_off", stat_misses, 32'd0);
`endif
        check("no_leftover_responses", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
